wb_bitstream_fifo: RTL and testbench
====================================

// Module: wb_bitstream_fifo
// PURPOSE
//  Wishbone slave that buffers FPGA configuration words from the Caravel management core.
//  Sits between the user_project_wrapper Wishbone slave port and the fpga250 config loader.
//  Drains words to the loader over a valid/ready stream, so software can burst writes
//  without waiting on the slower shift-chain load. Also exposes status and control registers.
// PARAMETERS
//  DEPTH      16            FIFO depth in 32-bit words; power of two, 2..128
//  ADDR_BASE  32'h3000_0000 register window base; 16-byte window (4 regs)
// PORTS
//  wb_clk_i      in   1   Wishbone clock; the only clock
//  wb_rst_n_i    in   1   async active-low reset; deassert synchronously to wb_clk_i
//  wbs_stb_i     in   1   Wishbone strobe
//  wbs_cyc_i     in   1   Wishbone cycle
//  wbs_we_i      in   1   1 = write
//  wbs_sel_i     in   4   byte selects
//  wbs_adr_i     in   32  byte address
//  wbs_dat_i     in   32  write data
//  wbs_ack_o     out  1   single-cycle acknowledge
//  wbs_dat_o     out  32  read data; valid only while wbs_ack_o=1, else 0
//  cfg_data_o    out  32  head-of-FIFO word to the config loader
//  cfg_valid_o   out  1   cfg_data_o valid (FIFO not empty)
//  cfg_ready_i   in   1   loader accepts the word when valid & ready
// BEHAVIOUR
//  Reset: ack=0, dat_o=0, cfg_valid_o=0, cfg_data_o=0, count=0, ptrs=0, overflow=0, checksum=0.
//  Register map (offset from ADDR_BASE; adr[1:0] ignored):
//   0x0 DATA  W: push word. R: returns 0.
//   0x4 STAT  R: [0] empty, [1] full, [2] overflow (sticky), [15:8] count. W: ignored.
//   0x8 CTRL  W: bit0 flush, bit1 clear overflow; self-clearing. R: 0.
//   0xC CSUM  R: checksum (see CONFIGURATION). W: ignored.
//  Request = stb & cyc & addr in window & !ack.
//  - ack is registered: asserted in the cycle after the request, for exactly 1 cycle.
//  - Addresses outside the window never ack; a held request gets no second ack.
//  - Write side effects commit on the same edge that raises ack.
//  Push: write to DATA with sel=4'hF.
//  - sel != 4'hF: acked, word dropped, overflow not set.
//  - Full: word dropped, overflow set, still acked (the bus is never stalled).
//  Pop: cfg_valid_o & cfg_ready_i at a rising edge.
//  - cfg_valid_o = (count != 0), registered view.
//  - cfg_data_o holds the head word, stable while valid & !ready; 0 when empty.
//  - First word: cfg_valid_o rises the cycle after the push edge (1-cycle latency).
//  Simultaneous push + pop:
//  - When full, the push is accepted (no overflow) and count is unchanged.
//  - When not full, count is unchanged and both pointers advance.
//  - Pop from empty cannot occur.
//  Flush (CTRL bit0): pointers and count to 0, cfg_valid_o=0 next cycle, checksum to 0.
//  - Flush beats a same-cycle pop; a flush write cannot coincide with a push.
//  - Overflow is cleared only by CTRL bit1. Bit0 and bit1 may be set together.
//  Pointers: log2(DEPTH) bits, wrap modulo DEPTH. count: log2(DEPTH)+1 bits, zero-extended into STAT[15:8].
//  Async reset mid-transfer: all state cleared immediately; the in-flight ack is lost (master retries).
// CONFIGURATION
//  BITSTREAM_CHECKSUM_EN defined:
//  - CSUM = 32-bit wrap-around sum of every popped word, cleared by reset or flush.
//  - Lets software verify the bitstream delivered to the loader.
//  Not defined: CSUM reads 0, no adder is built; all else identical.
// TESTING
//  1 Reset, read STAT -> 0x0000_0001; cfg_valid_o=0, ack pulse exactly 1 cycle.
//  2 Push 0xDEAD_BEEF with ready=0 -> valid next cycle, data stable 5 cycles; ready=1 -> popped, empty.
//  3 ready=0, push DEPTH+1 words -> STAT full=1, overflow=1, count=DEPTH; drain yields words 0..DEPTH-1 in order.
//  4 Full FIFO, ready=1 and push in same cycle -> count stays DEPTH, overflow=0, new word at tail.
//  5 Push 3 words, write CTRL=0x3 -> STAT=0x0000_0001 next read; sel=4'h3 write -> acked, count 0.
//  6 (CHECKSUM_EN) pop 0xFFFF_FFFF, 0x0000_0002 -> CSUM=0x0000_0001; without macro CSUM=0.

Source files
------------

// File: rtl/wb_bitstream_fifo.sv
// wb_bitstream_fifo
//   Wishbone slave that buffers FPGA configuration words written by the
//   management core and streams them to the config loader over valid/ready.
//
//   Optional feature macro: BITSTREAM_CHECKSUM_EN
//     defined   : CSUM register holds the 32-bit wrap-around sum of popped words
//     undefined : CSUM reads 0 and no adder is built
//
// Parameters
//   DEPTH      FIFO depth in 32-bit words (power of two, 2..128)
//   ADDR_BASE  base of the 16-byte register window
//
// Ports
//   wb_clk_i      in   Wishbone clock (only clock)
//   wb_rst_n_i    in   async active-low reset
//   wbs_stb_i     in   Wishbone strobe
//   wbs_cyc_i     in   Wishbone cycle
//   wbs_we_i      in   1 = write
//   wbs_sel_i     in   byte selects
//   wbs_adr_i     in   byte address
//   wbs_dat_i     in   write data
//   wbs_ack_o     out  single-cycle acknowledge
//   wbs_dat_o     out  read data, 0 unless wbs_ack_o
//   cfg_data_o    out  head-of-FIFO word, 0 when empty
//   cfg_valid_o   out  FIFO not empty
//   cfg_ready_i   in   loader accepts the head word when valid & ready
//
// Register map (adr[1:0] ignored)
//   0x0 DATA  W: push (sel must be 4'hF)   R: 0
//   0x4 STAT  R: [0] empty [1] full [2] overflow [15:8] count
//   0x8 CTRL  W: [0] flush [1] clear overflow   R: 0
//   0xC CSUM  R: checksum

module wb_bitstream_fifo #(
    parameter int unsigned DEPTH     = 16,
    parameter logic [31:0] ADDR_BASE = 32'h3000_0000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [31:0] cfg_data_o,
    output logic        cfg_valid_o,
    input  logic        cfg_ready_i
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    localparam logic [1:0] REG_DATA = 2'd0;
    localparam logic [1:0] REG_STAT = 2'd1;
    localparam logic [1:0] REG_CTRL = 2'd2;
    localparam logic [1:0] REG_CSUM = 2'd3;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          ack_q, ack_d;
    logic [31:0]   dat_q, dat_d;
    logic [31:0]   mem_q [DEPTH];

    logic          in_win;
    logic          req;
    logic [1:0]    reg_sel;
    logic          empty;
    logic          full;
    logic          pop;
    logic          push_req;
    logic          push_acc;
    logic          flush;
    logic          clr_ovf;
    logic [31:0]   head;
    logic [31:0]   csum_rd;
    logic [7:0]    cnt8;
    logic [31:0]   stat;
    logic          unused_adr;

    assign unused_adr = ^wbs_adr_i[1:0];

    assign in_win  = (wbs_adr_i[31:4] == ADDR_BASE[31:4]);
    // !ack_q keeps a request that is still held during its ack cycle from
    // being acknowledged twice back-to-back.
    assign req     = wbs_stb_i & wbs_cyc_i & in_win & ~ack_q;
    assign reg_sel = wbs_adr_i[3:2];

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign pop   = ~empty & cfg_ready_i;
    assign head  = mem_q[rd_ptr_q];

    assign push_req = req & wbs_we_i & (reg_sel == REG_DATA) & (wbs_sel_i == 4'hF);
    // A pop on the same edge frees the slot, so a push into a full FIFO
    // is still accepted in that case.
    assign push_acc = push_req & (~full | pop);
    assign flush    = req & wbs_we_i & (reg_sel == REG_CTRL) & wbs_dat_i[0];
    assign clr_ovf  = req & wbs_we_i & (reg_sel == REG_CTRL) & wbs_dat_i[1];

    assign cfg_valid_o = ~empty;
    assign cfg_data_o  = empty ? '0 : head;
    assign wbs_ack_o   = ack_q;
    assign wbs_dat_o   = dat_q;

    always_comb begin
        cnt8           = '0;
        cnt8[CW-1:0]   = count_q;
        stat           = {16'h0000, cnt8, 5'b00000, ovf_q, full, empty};
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        ack_d    = req;
        dat_d    = '0;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_acc) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + {{AW{1'b0}}, push_acc} - {{AW{1'b0}}, pop};
        end

        if (push_req & full & ~pop) begin
            ovf_d = 1'b1;
        end
        if (clr_ovf) begin
            ovf_d = 1'b0;
        end

        if (req & ~wbs_we_i) begin
            case (reg_sel)
                REG_STAT: dat_d = stat;
                REG_CSUM: dat_d = csum_rd;
                default:  dat_d = '0;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            ack_q    <= 1'b0;
            dat_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            ack_q    <= ack_d;
            dat_q    <= dat_d;
        end
    end

    // Storage needs no reset: only words between the pointers are ever visible.
    always_ff @(posedge wb_clk_i) begin
        if (push_acc & ~flush) begin
            mem_q[wr_ptr_q] <= wbs_dat_i;
        end
    end

`ifdef BITSTREAM_CHECKSUM_EN
    logic [31:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (flush) begin
            csum_d = '0;
        end else if (pop) begin
            csum_d = csum_q + head;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign csum_rd = csum_q;
`else
    assign csum_rd = '0;
`endif

endmodule

// File: tb/tb_wb_bitstream_fifo.sv
module tb_wb_bitstream_fifo;

    localparam int unsigned DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h3000_0000;

    logic        clk;
    logic        rst_n;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic [31:0] cfg_data_o;
    logic        cfg_valid_o;
    logic        cfg_ready_i;

    wb_bitstream_fifo #(
        .DEPTH     (DEPTH),
        .ADDR_BASE (BASE)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_n_i  (rst_n),
        .wbs_stb_i   (wbs_stb_i),
        .wbs_cyc_i   (wbs_cyc_i),
        .wbs_we_i    (wbs_we_i),
        .wbs_sel_i   (wbs_sel_i),
        .wbs_adr_i   (wbs_adr_i),
        .wbs_dat_i   (wbs_dat_i),
        .wbs_ack_o   (wbs_ack_o),
        .wbs_dat_o   (wbs_dat_o),
        .cfg_data_o  (cfg_data_o),
        .cfg_valid_o (cfg_valid_o),
        .cfg_ready_i (cfg_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: queue of stored words plus sticky flags.
    logic [31:0] mq[$];
    bit          m_ovf;
    logic [31:0] m_csum;
    bit          m_ack;
    bit          exp_ack;
    logic [31:0] exp_rd;

    function automatic logic [31:0] m_stat();
        int n;
        n = mq.size();
        return {16'h0000, 8'(n), 5'b00000, m_ovf, (n == DEPTH), (n == 0)};
    endfunction

    function automatic logic [31:0] m_csum_rd();
`ifdef BITSTREAM_CHECKSUM_EN
        return m_csum;
`else
        return 32'h0;
`endif
    endfunction

    function automatic logic [31:0] m_head();
        if (mq.size() == 0) return 32'h0;
        return mq[0];
    endfunction

    task automatic model_clear();
        mq.delete();
        m_ovf  = 0;
        m_csum = 32'h0;
        m_ack  = 0;
    endtask

    // Advance one clock, applying the bus/stream rules to the model first.
    task automatic tick();
        bit         req;
        bit         pop;
        bit         flush;
        bit         clr;
        bit         push;
        logic [1:0] rs;
        logic [31:0] a;
        a   = wbs_adr_i;
        rs  = a[3:2];
        req = wbs_stb_i && wbs_cyc_i && (a[31:4] == BASE[31:4]) && !m_ack;
        exp_ack = req;
        exp_rd  = 32'h0;
        if (req && !wbs_we_i) begin
            if (rs == 2'd1)      exp_rd = m_stat();
            else if (rs == 2'd3) exp_rd = m_csum_rd();
        end
        flush = req && wbs_we_i && rs == 2'd2 && wbs_dat_i[0];
        clr   = req && wbs_we_i && rs == 2'd2 && wbs_dat_i[1];
        push  = req && wbs_we_i && rs == 2'd0 && wbs_sel_i == 4'hF;
        pop   = cfg_ready_i && mq.size() != 0;
        if (flush) begin
            mq.delete();
            m_csum = 32'h0;
        end else begin
            if (pop) begin
                m_csum = m_csum + mq[0];
                void'(mq.pop_front());
            end
            if (push) begin
                if (mq.size() < DEPTH) mq.push_back(wbs_dat_i);
                else m_ovf = 1;
            end
        end
        if (clr) m_ovf = 0;
        m_ack = req;
        @(posedge clk);
        #1;
    endtask

    task automatic xfer(input bit w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rdata,
                        output bit acked, output bit ack_after);
        wbs_stb_i = 1; wbs_cyc_i = 1; wbs_we_i = w;
        wbs_adr_i = a; wbs_dat_i = d; wbs_sel_i = s;
        tick();
        acked = wbs_ack_o;
        rdata = wbs_dat_o;
        wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0;
        tick();
        ack_after = wbs_ack_o;
    endtask

    logic [31:0] rv;
    bit          ak;
    bit          ak2;

    task automatic test_reset();
        rst_n = 0;
        model_clear();
        @(posedge clk); #1;
        checks++; if (wbs_ack_o !== 1'b0) begin errors++; $display("FAIL reset_ack got %0b want 0", wbs_ack_o); end
        checks++; if (wbs_dat_o !== 32'h0) begin errors++; $display("FAIL reset_dat got %h want 0", wbs_dat_o); end
        checks++; if (cfg_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", cfg_valid_o); end
        checks++; if (cfg_data_o !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 0", cfg_data_o); end
        rst_n = 1;
        tick();
        xfer(0, BASE + 32'h4, 32'h0, 4'hF, rv, ak, ak2);
        checks++; if (ak !== 1'b1) begin errors++; $display("FAIL reset_stat_ack got %0b want 1", ak); end
        checks++; if (ak2 !== 1'b0) begin errors++; $display("FAIL reset_ack_width got %0b want 0", ak2); end
        checks++; if (rv !== 32'h0000_0001) begin errors++; $display("FAIL reset_stat got %h want 00000001", rv); end
    endtask

    task automatic test_single();
        cfg_ready_i = 0;
        wbs_stb_i = 1; wbs_cyc_i = 1; wbs_we_i = 1;
        wbs_adr_i = BASE; wbs_dat_i = 32'hDEAD_BEEF; wbs_sel_i = 4'hF;
        tick();
        checks++; if (wbs_ack_o !== 1'b1) begin errors++; $display("FAIL single_ack got %0b want 1", wbs_ack_o); end
        checks++; if (cfg_valid_o !== 1'b1) begin errors++; $display("FAIL single_valid got %0b want 1", cfg_valid_o); end
        wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (cfg_valid_o !== 1'b1 || cfg_data_o !== 32'hDEAD_BEEF) begin
                errors++; $display("FAIL single_hold cyc %0d got %0b/%h want 1/deadbeef", i, cfg_valid_o, cfg_data_o);
            end
        end
        cfg_ready_i = 1;
        tick();
        cfg_ready_i = 0;
        checks++; if (cfg_valid_o !== 1'b0 || cfg_data_o !== 32'h0) begin errors++; $display("FAIL single_pop got %0b/%h want 0/0", cfg_valid_o, cfg_data_o); end
        xfer(0, BASE, 32'h0, 4'hF, rv, ak, ak2);
        checks++; if (rv !== 32'h0) begin errors++; $display("FAIL data_read got %h want 0", rv); end
        xfer(0, BASE + 32'h8, 32'h0, 4'hF, rv, ak, ak2);
        checks++; if (rv !== 32'h0) begin errors++; $display("FAIL ctrl_read got %h want 0", rv); end
    endtask

    task automatic test_overflow();
        logic [31:0] words [DEPTH+1];
        cfg_ready_i = 0;
        for (int i = 0; i <= DEPTH; i++) begin
            words[i] = $urandom;
            xfer(1, BASE, words[i], 4'hF, rv, ak, ak2);
        end
        checks++; if (ak !== 1'b1) begin errors++; $display("FAIL ovf_ack got %0b want 1", ak); end
        xfer(0, BASE + 32'h4, 32'h0, 4'hF, rv, ak, ak2);
        checks++; if (rv !== ((32'(DEPTH) << 8) | 32'h6)) begin errors++; $display("FAIL ovf_stat got %h want %h", rv, (32'(DEPTH) << 8) | 32'h6); end
        cfg_ready_i = 1;
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (cfg_valid_o !== 1'b1 || cfg_data_o !== words[i]) begin
                errors++; $display("FAIL ovf_drain %0d got %0b/%h want 1/%h", i, cfg_valid_o, cfg_data_o, words[i]);
            end
            tick();
        end
        cfg_ready_i = 0;
        checks++; if (cfg_valid_o !== 1'b0) begin errors++; $display("FAIL ovf_empty got %0b want 0", cfg_valid_o); end
        xfer(0, BASE + 32'h4, 32'h0, 4'hF, rv, ak, ak2);
        checks++; if (rv !== 32'h0000_0005) begin errors++; $display("FAIL ovf_sticky got %h want 00000005", rv); end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] words [DEPTH];
        logic [31:0] nw;
        xfer(1, BASE + 32'h8, 32'h2, 4'hF, rv, ak, ak2);
        cfg_ready_i = 0;
        for (int i = 0; i < DEPTH; i++) begin
            words[i] = $urandom;
            xfer(1, BASE, words[i], 4'hF, rv, ak, ak2);
        end
        nw = $urandom;
        wbs_stb_i = 1; wbs_cyc_i = 1; wbs_we_i = 1;
        wbs_adr_i = BASE; wbs_dat_i = nw; wbs_sel_i = 4'hF;
        cfg_ready_i = 1;
        tick();
        cfg_ready_i = 0;
        wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0;
        checks++; if (wbs_ack_o !== 1'b1) begin errors++; $display("FAIL fpp_ack got %0b want 1", wbs_ack_o); end
        tick();
        xfer(0, BASE + 32'h4, 32'h0, 4'hF, rv, ak, ak2);
        checks++; if (rv !== ((32'(DEPTH) << 8) | 32'h2)) begin errors++; $display("FAIL fpp_stat got %h want %h", rv, (32'(DEPTH) << 8) | 32'h2); end
        cfg_ready_i = 1;
        for (int i = 1; i <= DEPTH; i++) begin
            checks++;
            if (cfg_data_o !== ((i == DEPTH) ? nw : words[i])) begin
                errors++; $display("FAIL fpp_drain %0d got %h want %h", i, cfg_data_o, (i == DEPTH) ? nw : words[i]);
            end
            tick();
        end
        cfg_ready_i = 0;
    endtask

    task automatic test_flush();
        cfg_ready_i = 0;
        for (int i = 0; i < 3; i++) xfer(1, BASE, $urandom, 4'hF, rv, ak, ak2);
        xfer(1, BASE + 32'h8, 32'h3, 4'hF, rv, ak, ak2);
        checks++; if (cfg_valid_o !== 1'b0) begin errors++; $display("FAIL flush_valid got %0b want 0", cfg_valid_o); end
        xfer(0, BASE + 32'h4, 32'h0, 4'hF, rv, ak, ak2);
        checks++; if (rv !== 32'h0000_0001) begin errors++; $display("FAIL flush_stat got %h want 00000001", rv); end
        xfer(1, BASE, 32'h1234_5678, 4'h3, rv, ak, ak2);
        checks++; if (ak !== 1'b1) begin errors++; $display("FAIL partial_ack got %0b want 1", ak); end
        xfer(0, BASE + 32'h4, 32'h0, 4'hF, rv, ak, ak2);
        checks++; if (rv !== 32'h0000_0001) begin errors++; $display("FAIL partial_stat got %h want 00000001", rv); end
    endtask

    task automatic test_checksum();
        logic [31:0] want;
`ifdef BITSTREAM_CHECKSUM_EN
        want = 32'h0000_0001;
`else
        want = 32'h0;
`endif
        cfg_ready_i = 0;
        xfer(1, BASE + 32'h8, 32'h1, 4'hF, rv, ak, ak2);
        xfer(1, BASE, 32'hFFFF_FFFF, 4'hF, rv, ak, ak2);
        xfer(1, BASE, 32'h0000_0002, 4'hF, rv, ak, ak2);
        cfg_ready_i = 1;
        tick(); tick(); tick();
        cfg_ready_i = 0;
        xfer(0, BASE + 32'hC, 32'h0, 4'hF, rv, ak, ak2);
        checks++; if (rv !== want) begin errors++; $display("FAIL csum got %h want %h", rv, want); end
    endtask

    task automatic test_window();
        logic [31:0] st;
        st = m_stat();
        xfer(1, BASE + 32'h10, 32'hAAAA_5555, 4'hF, rv, ak, ak2);
        checks++; if (ak !== 1'b0 || ak2 !== 1'b0) begin errors++; $display("FAIL win_hi_ack got %0b%0b want 00", ak, ak2); end
        xfer(1, BASE - 32'h4, 32'hAAAA_5555, 4'hF, rv, ak, ak2);
        checks++; if (ak !== 1'b0 || ak2 !== 1'b0) begin errors++; $display("FAIL win_lo_ack got %0b%0b want 00", ak, ak2); end
        xfer(0, BASE + 32'h7, 32'h0, 4'hF, rv, ak, ak2);
        checks++; if (rv !== st) begin errors++; $display("FAIL win_stat got %h want %h", rv, st); end
    endtask

    task automatic test_async_reset();
        cfg_ready_i = 0;
        xfer(1, BASE, $urandom, 4'hF, rv, ak, ak2);
        wbs_stb_i = 1; wbs_cyc_i = 1; wbs_we_i = 1;
        wbs_adr_i = BASE; wbs_dat_i = $urandom; wbs_sel_i = 4'hF;
        tick();
        #2;
        rst_n = 0;
        #1;
        model_clear();
        checks++; if (wbs_ack_o !== 1'b0 || cfg_valid_o !== 1'b0) begin errors++; $display("FAIL areset got %0b/%0b want 0/0", wbs_ack_o, cfg_valid_o); end
        wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0;
        @(posedge clk); #1;
        rst_n = 1;
        tick();
        xfer(0, BASE + 32'h4, 32'h0, 4'hF, rv, ak, ak2);
        checks++; if (rv !== 32'h0000_0001) begin errors++; $display("FAIL areset_stat got %h want 00000001", rv); end
    endtask

    task automatic test_random();
        int unsigned pct;
        int unsigned op;
        logic [31:0] d;
        pct = 0;
        for (int k = 0; k < 1200; k++) begin
            if (k % 100 == 0) begin
                case ($urandom_range(0, 3))
                    0: pct = 0;
                    1: pct = 15;
                    2: pct = 50;
                    default: pct = 90;
                endcase
            end
            cfg_ready_i = ($urandom_range(0, 99) < pct);
            if (wbs_stb_i) begin
                wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0;
            end else if ($urandom_range(0, 99) < 70) begin
                op = $urandom_range(0, 19);
                d  = $urandom;
                wbs_sel_i = 4'hF;
                wbs_we_i  = 1;
                wbs_adr_i = BASE | 32'($urandom_range(0, 3));
                if (op < 12) begin
                    if ($urandom_range(0, 9) == 0) wbs_sel_i = 4'($urandom);
                end else if (op < 15) begin
                    wbs_we_i = 0; wbs_adr_i = wbs_adr_i | 32'h4;
                end else if (op == 15) begin
                    wbs_we_i = 0; wbs_adr_i = wbs_adr_i | 32'hC;
                end else if (op == 16) begin
                    wbs_we_i = 0; wbs_adr_i = wbs_adr_i | 32'h8;
                end else if (op == 17) begin
                    wbs_adr_i = wbs_adr_i | 32'h8;
                    if ($urandom_range(0, 3) != 0) d[0] = 1'b0;
                end else if (op == 18) begin
                    wbs_adr_i = wbs_adr_i ^ (32'h1 << $urandom_range(4, 31));
                end else begin
                    wbs_adr_i = wbs_adr_i | 32'h4;
                end
                wbs_dat_i = d;
                wbs_stb_i = 1; wbs_cyc_i = 1;
            end
            tick();
            checks++;
            if (wbs_ack_o !== exp_ack || wbs_dat_o !== exp_rd) begin
                errors++; $display("FAIL rnd_bus k=%0d got %0b/%h want %0b/%h", k, wbs_ack_o, wbs_dat_o, exp_ack, exp_rd);
            end
            checks++;
            if (cfg_valid_o !== (mq.size() != 0) || cfg_data_o !== m_head()) begin
                errors++; $display("FAIL rnd_cfg k=%0d got %0b/%h want %0b/%h", k, cfg_valid_o, cfg_data_o, mq.size() != 0, m_head());
            end
        end
        wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0; cfg_ready_i = 0;
        tick();
    endtask

    initial begin
        rst_n = 0;
        wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0;
        wbs_sel_i = 4'h0; wbs_adr_i = 32'h0; wbs_dat_i = 32'h0;
        cfg_ready_i = 0;
        model_clear();
        exp_ack = 0;
        exp_rd  = 32'h0;
        #1;
        test_reset();
        test_single();
        test_overflow();
        test_full_push_pop();
        test_flush();
        test_checksum();
        test_window();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
